// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-through data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_FILL = 2'd2
  } state_e;

  // Word width of a cache line and of the DRAM data path.
  localparam int unsigned DATA_W   = 32;
  // Byte-address range of DRAM; tag bits stop at the top of this range.
  localparam int unsigned DRAM_AW  = 27;
  // Tag width is TAG_BASE - IDX_W (27 address bits minus the 2 byte-offset bits).
  localparam int unsigned TAG_BASE = 25;

  function automatic int unsigned tag_w(input int unsigned idx_w);
    return TAG_BASE - idx_w;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// LINES-deep 1R1W line store of {valid, tag, data}; synchronous read, masked write.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int unsigned LINES = 1024,
  parameter int unsigned IDX_W = $clog2(LINES),
  parameter int unsigned TAG_W = tag_w(IDX_W)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rd_en_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic              rd_valid_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              wr_v_en_i,
  input  logic              wr_p_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic              wr_valid_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [DATA_W-1:0] wr_data_i
);

  localparam int unsigned LINE_W = 1 + TAG_W + DATA_W;

  logic [LINE_W-1:0] mem_q [LINES];
  logic [LINE_W-1:0] rd_q;

  // Write port: valid lane and {tag, data} lane have separate enables so a valid clear leaves the payload alone.
  always_ff @(posedge clk_i) begin
    if (wr_v_en_i) mem_q[wr_idx_i][LINE_W-1] <= wr_valid_i;
    if (wr_p_en_i) mem_q[wr_idx_i][LINE_W-2:0] <= {wr_tag_i, wr_data_i};
  end

  // Registered read port; holds its last value between reads.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      rd_q <= '0;
    else if (rd_en_i) rd_q <= mem_q[rd_idx_i];
  end

  assign rd_valid_o = rd_q[LINE_W-1];
  assign rd_tag_o   = rd_q[LINE_W-2 -: TAG_W];
  assign rd_data_o  = rd_q[DATA_W-1:0];

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through, one-word-per-line data cache with an INIT valid sweep and a blocking read fill.
module dcache
  import dcache_pkg::*;
#(
  parameter int unsigned LINES = 1024,
  parameter int unsigned IDX_W = $clog2(LINES)
) (
  input  logic        CLK,
  input  logic        RST_X,
  input  logic        oe,
  input  logic [31:0] addr,
  input  logic [3:0]  we,
  input  logic [31:0] wdata,
  input  logic        dram_valid,
  input  logic [31:0] dram_rdata,
  output logic        hit,
  output logic        miss,
  output logic [31:0] rdata,
  output logic        busy
);

  localparam int unsigned TAG_W = tag_w(IDX_W);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   lat_idx_q, lat_idx_d;
  logic [TAG_W-1:0]   lat_tag_q, lat_tag_d;
  logic               rd_pend_q, rd_pend_d;

  logic [IDX_W-1:0]   req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic               arr_valid;
  logic [TAG_W-1:0]   arr_tag;
  logic [DATA_W-1:0]  arr_data;

  logic               rd_en;
  logic               wr_v_en, wr_p_en, wr_valid;
  logic [IDX_W-1:0]   wr_idx;
  logic [TAG_W-1:0]   wr_tag;
  logic [DATA_W-1:0]  wr_data;

  logic               unused_addr;

  assign req_idx     = addr[2 +: IDX_W];
  assign req_tag     = addr[DRAM_AW-1 : 2+IDX_W];
  assign unused_addr = ^{addr[31:DRAM_AW], addr[1:0]};

  // Lookup result is resolved in the cycle after acceptance, off the registered array read.
  assign hit   = rd_pend_q && arr_valid && (arr_tag == lat_tag_q);
  assign miss  = rd_pend_q && !hit;
  assign busy  = (state_q != ST_IDLE) || miss;
  assign rdata = arr_data;

  // State, sweep counter, latched request and pending-lookup flag.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      lat_idx_q <= '0;
      lat_tag_q <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lat_idx_q <= lat_idx_d;
      lat_tag_q <= lat_tag_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  // Next state and array port control.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lat_idx_d = lat_idx_q;
    lat_tag_d = lat_tag_q;
    rd_pend_d = 1'b0;
    rd_en     = 1'b0;
    wr_v_en   = 1'b0;
    wr_p_en   = 1'b0;
    wr_idx    = req_idx;
    wr_valid  = 1'b0;
    wr_tag    = req_tag;
    wr_data   = wdata;

    unique case (state_q)
      ST_INIT: begin
        wr_v_en = 1'b1;
        wr_idx  = cnt_q;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(LINES - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (miss) begin
          state_d = ST_FILL;
        end else if (oe) begin
          if (we == 4'b0000) begin
            rd_en     = 1'b1;
            rd_pend_d = 1'b1;
            lat_idx_d = req_idx;
            lat_tag_d = req_tag;
          end else if (we == 4'b1111) begin
            wr_v_en  = 1'b1;
            wr_p_en  = 1'b1;
            wr_valid = 1'b1;
          end else begin
            wr_v_en = 1'b1;
          end
        end
      end
      ST_FILL: begin
        if (dram_valid) begin
          wr_v_en  = 1'b1;
          wr_p_en  = 1'b1;
          wr_idx   = lat_idx_q;
          wr_valid = 1'b1;
          wr_tag   = lat_tag_q;
          wr_data  = dram_rdata;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  dcache_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk_i      (CLK),
    .rst_ni     (RST_X),
    .rd_en_i    (rd_en),
    .rd_idx_i   (req_idx),
    .rd_valid_o (arr_valid),
    .rd_tag_o   (arr_tag),
    .rd_data_o  (arr_data),
    .wr_v_en_i  (wr_v_en),
    .wr_p_en_i  (wr_p_en),
    .wr_idx_i   (wr_idx),
    .wr_valid_i (wr_valid),
    .wr_tag_i   (wr_tag),
    .wr_data_i  (wr_data)
  );

endmodule

// File: tb/tb_dcache.sv
// Scoreboard bench for dcache: directed scenarios plus randomized traffic against a line-array model.
module tb_dcache;

  localparam int unsigned LINES = 64;
  localparam int unsigned IDX_W = 6;
  localparam int unsigned TAG_W = 25 - IDX_W;

  logic        CLK = 1'b0;
  logic        RST_X = 1'b0;
  logic        oe = 1'b0;
  logic [31:0] addr = '0;
  logic [3:0]  we = '0;
  logic [31:0] wdata = '0;
  logic        dram_valid = 1'b0;
  logic [31:0] dram_rdata = '0;
  logic        hit, miss, busy;
  logic [31:0] rdata;

  always #5 CLK = ~CLK;

  dcache #(.LINES(LINES), .IDX_W(IDX_W)) dut (
    .CLK(CLK), .RST_X(RST_X), .oe(oe), .addr(addr), .we(we), .wdata(wdata),
    .dram_valid(dram_valid), .dram_rdata(dram_rdata),
    .hit(hit), .miss(miss), .rdata(rdata), .busy(busy)
  );

  typedef struct {
    bit          is_hit;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;

  // Reference: what each cache line holds, by the cache's own addressing rules.
  bit               m_valid [LINES];
  logic [TAG_W-1:0] m_tag   [LINES];
  logic [31:0]      m_data  [LINES];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic int unsigned idx_of(input logic [31:0] a);
    return (a >> 2) % LINES;
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] a);
    return TAG_W'((a % (32'd1 << 27)) / (32'd4 * LINES));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // Monitor: every hit/miss the DUT presents is matched against the oldest expected lookup.
  always @(negedge CLK) begin
    if (RST_X) begin
      if (hit && miss) begin
        check("hit_miss_exclusive", 32'(hit & miss), 32'd0);
      end else if (hit || miss) begin
        if (exp_q.size() == 0) begin
          check("unexpected_lookup", 32'(hit), 32'd2);
        end else begin
          e_mon = exp_q.pop_front();
          check("hit_flag", 32'(hit), 32'(e_mon.is_hit));
          if (e_mon.is_hit && hit) check("rdata", rdata, e_mon.data);
        end
      end
    end
  end

  task automatic model_clear();
    for (int i = 0; i < int'(LINES); i++) m_valid[i] = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n >= 200) bound_fail("wait_idle");
  endtask

  // Counts busy cycles after reset release (called at posedge+#1 right after RST_X rises).
  task automatic measure_init(input string name);
    int n = 0;
    @(negedge CLK);
    while (busy && n < 300) begin
      n++;
      @(negedge CLK);
    end
    check(name, 32'(n), 32'(LINES));
    @(posedge CLK); #1;
  endtask

  task automatic do_read(input logic [31:0] a, input int delay, input logic [31:0] fill);
    exp_t e;
    int   ix;
    wait_idle();
    ix = int'(idx_of(a));
    e.is_hit = m_valid[ix] && (m_tag[ix] == tag_of(a));
    e.data   = m_data[ix];
    exp_q.push_back(e);
    oe = 1'b1; we = 4'b0000; addr = a;
    @(posedge CLK); #1;
    oe = 1'b0;
    if (e.is_hit) begin
      check("busy_on_hit", 32'(busy), 32'd0);
    end else begin
      check("busy_on_miss", 32'(busy), 32'd1);
      dram_valid = 1'($urandom_range(0, 1));
      dram_rdata = ~fill;
      for (int k = 0; k < delay; k++) begin
        @(posedge CLK); #1;
        dram_valid = 1'b0;
      end
      dram_valid = 1'b1; dram_rdata = fill;
      @(posedge CLK); #1;
      dram_valid = 1'b0;
      m_valid[ix] = 1'b1; m_tag[ix] = tag_of(a); m_data[ix] = fill;
      check("busy_after_fill", 32'(busy), 32'd0);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d, input logic stray);
    int ix;
    wait_idle();
    ix = int'(idx_of(a));
    oe = 1'b1; we = be; addr = a; wdata = d;
    dram_valid = stray; dram_rdata = ~d;
    @(posedge CLK); #1;
    oe = 1'b0; we = 4'b0000; dram_valid = 1'b0;
    if (be == 4'b1111) begin
      m_valid[ix] = 1'b1; m_tag[ix] = tag_of(a); m_data[ix] = d;
    end else begin
      m_valid[ix] = 1'b0;
    end
    check("busy_after_write", 32'(busy), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    logic [3:0]  be;
    model_clear();

    // Reset values
    repeat (3) @(negedge CLK);
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_miss", 32'(miss), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_rdata", rdata, 32'd0);
    @(posedge CLK); #1;
    RST_X = 1'b1;
    measure_init("init_busy_cycles");

    // Cold miss, fill after 5 cycles, then hit
    do_read(32'h0000_0100, 5, 32'hCAFE_BABE);
    do_read(32'h0000_0100, 1, 32'h0);

    // Full write then immediate read of the same line
    do_write(32'h0000_0200, 4'b1111, 32'h1234_5678, 1'b0);
    do_read(32'h0000_0200, 1, 32'h0);

    // Partial write invalidates a cached line
    do_read(32'h0000_0300, 2, 32'h3333_0300);
    do_read(32'h0000_0300, 1, 32'h0);
    do_write(32'h0000_0300, 4'b0001, 32'hFFFF_FFFF, 1'b0);
    do_read(32'h0000_0300, 3, 32'h3030_3030);

    // Tag conflict on index 0
    do_read(32'h0000_0000, 2, 32'h0000_AAAA);
    do_read(32'h0000_0100, 2, 32'h0000_BBBB);
    do_read(32'h0000_0000, 2, 32'h0000_CCCC);
    do_read(32'h0000_0000, 1, 32'h0);

    // Reset two cycles into a fill; the late DRAM return must be ignored
    wait_idle();
    begin
      exp_t e;
      e.is_hit = 1'b0; e.data = '0;
      exp_q.push_back(e);
    end
    oe = 1'b1; we = 4'b0000; addr = 32'h0000_0400;
    @(posedge CLK); #1;
    oe = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST_X = 1'b0;
    #1;
    check("rst_fill_busy", 32'(busy), 32'd1);
    check("rst_fill_miss", 32'(miss), 32'd0);
    @(posedge CLK); #1;
    RST_X = 1'b1;
    dram_valid = 1'b1; dram_rdata = 32'hDEAD_BEEF;
    model_clear();
    @(posedge CLK); #1;
    dram_valid = 1'b0;
    begin
      int n = 1;
      while (busy && n < 300) begin
        @(posedge CLK); #1;
        n++;
      end
      check("reinit_busy_cycles", 32'(n), 32'(LINES));
    end
    do_read(32'h0000_0400, 1, 32'h4444_0400);
    do_read(32'h0000_0100, 1, 32'h5555_0100);

    // Randomized traffic over a few indices and tags
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      a[26:8] = 19'($urandom_range(0, 3));
      a[7:2]  = 6'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0, 1: do_read(a, int'($urandom_range(1, 6)), $urandom);
        2:    do_write(a, 4'b1111, $urandom, 1'($urandom_range(0, 1)));
        default: begin
          be = 4'($urandom_range(1, 14));
          do_write(a, be, $urandom, 1'($urandom_range(0, 1)));
        end
      endcase
    end

    wait_idle();
    repeat (2) @(negedge CLK);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dcache.md
DCACHE -- requirements
Module: dcache

Interface
REQ-001 Parameter LINES, default 1024, number of one-word lines; power of two, 64..4096.
REQ-002 Parameter IDX_W, default $clog2(LINES), index width.
REQ-003 One clock; reset is asynchronous and active-low. Port CLK, input, 1, rising-edge clock.
REQ-004 RST_X  input  1  asynchronous active-low reset.
REQ-005 oe  input  1  data-memory access request for the current cycle (DRAM range only).
REQ-006 addr  input  32  byte address of the request; bits 1:0 ignored.
REQ-007 we  input  4  byte write enables; zero means read.
REQ-008 wdata  input  32  store data, byte lanes aligned to we.
REQ-009 dram_valid  input  1  one-cycle pulse: DRAM read data returned.
REQ-010 dram_rdata  input  32  DRAM read data, qualified by dram_valid.
REQ-011 hit  output  1  read hit; rdata valid this cycle.
REQ-012 miss  output  1  one-cycle pulse: read miss, DRAM read to be issued.
REQ-013 rdata  output  32  cached read data.
REQ-014 busy  output  1  cache cannot accept a request.

Function
REQ-015 Direct-mapped, write-through, one 32-bit word per line; index = addr[2+:IDX_W], tag = addr[26:2+IDX_W], valid bit per line.
REQ-016 States: INIT, IDLE, FILL; INIT entered on reset, sweeps index 0..LINES-1 clearing valid, one line per cycle, then IDLE.
REQ-017 busy = 1 in INIT, in FILL, and in any cycle miss = 1.
REQ-018 oe is sampled only in IDLE with busy = 0; oe in any other cycle is ignored with no state change.
REQ-019 Read accepted at cycle t (we = 0): tag/valid/data read synchronously; at t+1 exactly one of hit or miss is 1.
REQ-020 Read hit: hit = 1 and rdata = stored word at t+1; no state change.
REQ-021 Read miss: miss = 1 at t+1; index and tag latched; next state FILL.
REQ-022 FILL: wait any number of cycles for dram_valid; on dram_valid write dram_rdata, tag, valid = 1 to latched index; next cycle IDLE, busy = 0.
REQ-023 dram_valid outside FILL is ignored.
REQ-024 Write we = 4'b1111 at cycle t: line at index written with wdata, tag, valid = 1 at t (allocate); hit and miss stay 0.
REQ-025 Partial write (we nonzero, not 4'b1111) at t: valid at index cleared at t; data/tag untouched; hit and miss stay 0.
REQ-026 Write never sets busy; a read at t+1 to the index written at t observes the write.
REQ-027 hit and miss are never 1 in the same cycle; neither is 1 in INIT or FILL.
REQ-028 rdata is don't-care when hit = 0; holds last value (no X propagation requirement).

Reset
REQ-029 On RST_X low: state = INIT, sweep counter = 0, hit = 0, miss = 0, busy = 1, rdata = 0, latched index/tag = 0.
REQ-030 Reset mid-FILL or mid-INIT aborts the operation and restarts the full INIT sweep; a later dram_valid for the aborted fill is ignored.
REQ-031 Array contents are not reset; only valid bits are cleared, by the INIT sweep (LINES cycles after RST_X release).

Structure
REQ-032 Package dcache_pkg holds the state encoding (INIT, IDLE, FILL), tag-width constant (25 - IDX_W), and the 27-bit DRAM address-range constant.
REQ-033 One sub-module dcache_array: LINES-deep synchronous-read 1R1W memory of {valid, tag, data}, one instance, inferable as block RAM; valid clears go through its write port.

Verification
REQ-034 Release reset, LINES=64 -> busy = 1 for exactly 64 cycles, then 0; a read of 0x100 then gives miss = 1, hit = 0.
REQ-035 Read 0x100 miss; dram_valid with 0xCAFEBABE after 5 cycles -> busy low next cycle; re-read 0x100 -> hit = 1, rdata = 0xCAFEBABE.
REQ-036 Full write 0x200 = 0x12345678 at t, read 0x200 at t+1 -> hit = 1 at t+2, rdata = 0x12345678, busy never 1.
REQ-037 After 0x300 cached, byte write we = 4'b0001 to 0x300 -> next read of 0x300 gives miss = 1.
REQ-038 LINES=64: cache 0x000, read 0x100 (same index, different tag) -> miss = 1; after fill, read 0x000 -> miss = 1.
REQ-039 Reset asserted 2 cycles into FILL, then dram_valid pulses -> INIT sweep restarts, no line written, first read afterwards misses.
